// File: rtl/common_bus_arb_if.sv
// common_bus_arb_if: source/select/request inputs and registered bus outputs of the arbiter
interface common_bus_arb_if #(
  parameter int WIDTH = 8,
  parameter int NSRC  = 8
);
  localparam int SELW = $clog2(NSRC);
  logic [NSRC*WIDTH-1:0] src_data;
  logic                  mode;
  logic [SELW-1:0]       sel;
  logic [NSRC-1:0]       req;
  logic [NSRC-1:0]       grant;
  logic [WIDTH-1:0]      bus_out;
  logic                  bus_valid;
  logic [SELW-1:0]       bus_src;
  modport slave (input src_data, mode, sel, req, output grant, bus_out, bus_valid, bus_src);
  modport master (output src_data, mode, sel, req, input grant, bus_out, bus_valid, bus_src);
endinterface

// File: rtl/common_bus_arb.sv
// common_bus_arb: registered bus mux with direct-select and round-robin arbitrated modes
module common_bus_arb #(
  parameter int WIDTH    = 8,
  parameter int NSRC     = 8,
  parameter int MAX_HOLD = 4
) (
  input logic             clk,
  input logic             rst_n,
  common_bus_arb_if.slave bus
);
  localparam int SELW = $clog2(NSRC);
  localparam int HW   = $clog2(MAX_HOLD + 1);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t           state, state_n;
  logic [SELW-1:0]  ptr, ptr_n, src_n, win;
  logic [HW-1:0]    hold, hold_n;
  logic [NSRC-1:0]  grant_n;
  logic [WIDTH-1:0] out_n;
  logic             valid_n, mode_q;
  logic [WIDTH-1:0] src [NSRC];
  always_comb begin
    for (int i = 0; i < NSRC; i++) src[i] = bus.src_data[i*WIDTH +: WIDTH];
    win = '0;
    // scan downward so the nearest set bit after ptr is the last one written
    for (int k = NSRC; k >= 1; k--)
      if (bus.req[(int'(ptr) + k) % NSRC]) win = SELW'((int'(ptr) + k) % NSRC);
  end
  always_comb begin
    state_n = IDLE;
    ptr_n   = ptr;
    hold_n  = '0;
    grant_n = '0;
    out_n   = '0;
    valid_n = 1'b0;
    src_n   = '0;
    if (!bus.mode) begin
      if (state == GRANT) ptr_n = bus.bus_src;
      if (int'(bus.sel) < NSRC) begin
        out_n   = src[bus.sel];
        valid_n = 1'b1;
        src_n   = bus.sel;
      end
    end else if (state == GRANT) begin
      if (bus.req[bus.bus_src] && hold < HW'(MAX_HOLD)) begin
        state_n = GRANT;
        hold_n  = hold + 1'b1;
        grant_n = bus.grant;
        out_n   = src[bus.bus_src];
        valid_n = 1'b1;
        src_n   = bus.bus_src;
      end else begin
        ptr_n = bus.bus_src;
      end
    end else if (mode_q && |bus.req) begin
      // mode_q low means arbitration was just enabled: spend one edge idle first
      state_n      = GRANT;
      hold_n       = HW'(1);
      grant_n[win] = 1'b1;
      out_n        = src[win];
      valid_n      = 1'b1;
      src_n        = win;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      ptr           <= SELW'(NSRC - 1);
      hold          <= '0;
      mode_q        <= 1'b1;
      bus.grant     <= '0;
      bus.bus_out   <= '0;
      bus.bus_valid <= 1'b0;
      bus.bus_src   <= '0;
    end else begin
      state         <= state_n;
      ptr           <= ptr_n;
      hold          <= hold_n;
      mode_q        <= bus.mode;
      bus.grant     <= grant_n;
      bus.bus_out   <= out_n;
      bus.bus_valid <= valid_n;
      bus.bus_src   <= src_n;
    end
  end
endmodule

// File: doc/common_bus_arb.md
COMMON_BUS_ARB -- requirements
Module: common_bus_arb

Interface
- REQ-001 Parameter WIDTH, default 8: bit width of every source and of the bus.
- REQ-002 Parameter NSRC, default 8, legal range 2..16: number of bus sources.
- REQ-003 Parameter MAX_HOLD, default 4, minimum 1: maximum consecutive GRANT cycles per tenure.
- REQ-004 Derived constant SELW = ceil(log2(NSRC)), which is 3 at the defaults.
- REQ-005 clk, input, 1 bit: the single clock; all state updates on the rising edge.
- REQ-006 rst_n, input, 1 bit: reset, synchronous and active-low.
- REQ-007 src_data, input, NSRC*WIDTH bits: source i occupies bits [i*WIDTH +: WIDTH].
- REQ-008 mode, input, 1 bit: 0 selects direct-select mode; 1 selects arbitrated mode.
- REQ-009 sel, input, SELW bits: the source index used in direct mode.
- REQ-010 req, input, NSRC bits: per-source bus request, used in arbitrated mode.
- REQ-011 grant, output, NSRC bits, registered: one-hot or zero grant.
- REQ-012 bus_out, output, WIDTH bits, registered: the bus value.
- REQ-013 bus_valid, output, 1 bit, registered: bus_out carries a selected source.
- REQ-014 bus_src, output, SELW bits, registered: index of the source currently driving bus_out.

Function
- REQ-015 Every output SHALL be registered; no combinational path from any input to any output.
- REQ-016 Direct mode (mode=0), sel < NSRC, next edge: bus_out = src[sel], bus_src = sel, bus_valid = 1, grant = 0.
- REQ-017 Direct mode, sel >= NSRC, next edge: bus_out = 0, bus_valid = 0, bus_src = 0, grant = 0.
- REQ-018 Arbitrated mode SHALL use a two-state FSM, IDLE and GRANT.
- REQ-019 IDLE with req == 0: outputs SHALL be grant = 0, bus_valid = 0, bus_out = 0, and the FSM SHALL stay in IDLE.
- REQ-020 IDLE with any req bit set:
  - winner = first set req bit searching upward from (ptr+1) mod NSRC, with wrap-around;
  - next edge: grant = one-hot(winner), bus_src = winner, bus_out = src[winner], bus_valid = 1, hold counter = 1, state = GRANT.
- REQ-021 GRANT, req[winner] = 1 and hold counter < MAX_HOLD:
  - stay in GRANT;
  - bus_out SHALL re-sample src[winner] every cycle;
  - hold counter increments.
- REQ-022 GRANT, req[winner] = 0: next edge grant = 0, bus_valid = 0, bus_out = 0, ptr = winner, state = IDLE.
- REQ-023 GRANT, hold counter == MAX_HOLD with req[winner] still 1: forced release with the same outputs as REQ-022, ptr = winner.
- REQ-024 After any release, the FSM SHALL spend at least one cycle in IDLE (a bus turnaround cycle) before the next grant.
- REQ-025 Round-robin fairness: a source released by timeout SHALL NOT be re-granted while any other req bit is set.
- REQ-026 Requests from sources other than the winner SHALL be ignored during GRANT.
- REQ-027 Mode 1→0 while in GRANT: next edge follows REQ-016/017, state = IDLE, ptr = winner.
- REQ-028 Mode 0→1: the FSM starts in IDLE; the first arbitrated grant appears two edges after the change.
- REQ-029 grant SHALL never have more than one bit set.
- REQ-030 grant SHALL be zero whenever bus_valid = 0 or mode = 0.

Reset
- REQ-031 With rst_n = 0 at an edge, the following values SHALL apply at that edge, regardless of mode or state, including mid-tenure:
  - grant = 0, bus_out = 0, bus_valid = 0, bus_src = 0;
  - state = IDLE, hold counter = 0, ptr = NSRC-1 (source 0 has first priority).
- REQ-032 Inputs SHALL be ignored while rst_n = 0; the first grant can appear at the first edge after rst_n returns high.

Verification (defaults WIDTH=8, NSRC=8, MAX_HOLD=4)
- REQ-033 Direct-mode sweep:
  - stimulus: mode=0, src[i] = 8'h10+i, sel stepped 0..7 and then 6;
  - response: bus_out one cycle later = 8'h10..8'h17, bus_src = sel, bus_valid = 1, grant = 0;
  - at sel = 6, bus_out = 8'h16.
- REQ-034 Round robin from reset:
  - stimulus: mode=1, req = 8'b1000_0101 held, hold releases by timeout;
  - response: grant sequence 0x01, 0x04, 0x80, 0x01, each tenure 4 cycles followed by 1 idle cycle.
- REQ-035 Early release:
  - stimulus: req[3] asserted for 2 cycles, then dropped;
  - response: grant = 0x08 for 2 cycles, bus_src = 3, then grant = 0 and bus_valid = 0 on the edge after req[3] falls.
- REQ-036 Mid-tenure reset:
  - stimulus: during a grant of source 5, rst_n = 0 for 1 cycle with req = 0x21;
  - response: all outputs 0; after reset, source 0 is granted first.
- REQ-037 Mode switch:
  - stimulus: granting source 2, mode→0 with sel = 7;
  - response: next edge grant = 0, bus_out = src[7], bus_valid = 1.
- REQ-038 Invalid select (NSRC=6 build):
  - stimulus: mode=0, sel = 6;
  - response: bus_out = 0, bus_valid = 0.
